// File: rtl/axis_step_generator_pkg.sv
// Shared types and helpers for the single-axis step generator.
// Period helpers saturate so a ramp can never wrap around 32 bits.
package axis_step_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ACCEL  = 3'd2,
    ST_CRUISE = 3'd3,
    ST_DECEL  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int PAR_STEPS = 0;
  localparam int PAR_P0    = 1;
  localparam int PAR_PMIN  = 2;
  localparam int PAR_DELTA = 3;
  localparam int PAR_RAMP  = 4;

  localparam int DEFAULT_PULSE_W = 10;

  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // p - d, never below floor f and never underflowing
  function automatic logic [31:0] sub_floor(input logic [31:0] p, input logic [31:0] d,
                                            input logic [31:0] f);
    if (d >= p) return f;
    return max32(p - d, f);
  endfunction

  // p + d computed in 33 bits, clamped to ceiling c
  function automatic logic [31:0] add_clamp(input logic [31:0] p, input logic [31:0] d,
                                            input logic [31:0] c);
    logic [32:0] sum;
    sum = {1'b0, p} + {1'b0, d};
    return (sum > {1'b0, c}) ? c : sum[31:0];
  endfunction

endpackage

// File: rtl/axis_step_generator_step_timer.sv
// Period down-counter and pulse-width counter for one step output.
// due is high while the period counter sits at zero; fire restarts both counters.
module step_timer
  import axis_step_generator_pkg::*;
#(
  parameter int PULSE_W = DEFAULT_PULSE_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        fire,
  input  logic [31:0] period,
  output logic        due,
  output logic        step
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pw_q, pw_d;
  logic        step_q, step_d;

  always_comb begin
    cnt_d  = cnt_q;
    pw_d   = pw_q;
    step_d = step_q;
    if (load)              cnt_d = '0;
    else if (fire)         cnt_d = period - 32'd1;
    else if (cnt_q != '0)  cnt_d = cnt_q - 32'd1;
    // pulse runs independently of the period so an abort never clips it
    if (fire) begin
      step_d = 1'b1;
      pw_d   = 32'(PULSE_W - 1);
    end else if (pw_q != '0) begin
      pw_d = pw_q - 32'd1;
    end else begin
      step_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pw_q   <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pw_q   <= pw_d;
      step_q <= step_d;
    end
  end

  assign due  = (cnt_q == '0);
  assign step = step_q;

endmodule

// File: rtl/axis_step_generator.sv
// Trapezoidal step generator: accel/cruise/decel ramp of step periods for one axis.
// First step 2 cycles after start; finish is held until start is released.
module axis_step_generator
  import axis_step_generator_pkg::*;
#(
  parameter int PULSE_W = DEFAULT_PULSE_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] par [0:4],
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic [31:0] steps_done,
  output logic        finish
);

  localparam logic [31:0] PW2 = 32'(2 * PULSE_W);

  state_e      state_q, state_d;
  logic [31:0] n_q, n_d, p_q, p_d, p0_q, p0_d, f_q, f_d, d_q, d_d;
  logic [31:0] na_q, na_d, cend_q, cend_d, steps_done_q, steps_done_d;
  logic        dir_q, dir_d, finish_q, finish_d;
  logic        fire, tmr_load, due;
  logic [31:0] fire_per, s_abs, na_ld, nd_ld;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    p_d          = p_q;
    p0_d         = p0_q;
    f_d          = f_q;
    d_d          = d_q;
    na_d         = na_q;
    cend_d       = cend_q;
    steps_done_d = steps_done_q;
    dir_d        = dir_q;
    finish_d     = finish_q;
    fire         = 1'b0;
    tmr_load     = 1'b0;
    fire_per     = p_q;
    s_abs        = par[PAR_STEPS][31] ? (~par[PAR_STEPS] + 32'd1) : par[PAR_STEPS];
    na_ld        = min32(par[PAR_RAMP], s_abs >> 1);
    nd_ld        = min32(par[PAR_RAMP], s_abs - na_ld);

    case (state_q)
      ST_IDLE: begin
        finish_d = 1'b0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tmr_load     = 1'b1;
        n_d          = s_abs;
        dir_d        = par[PAR_STEPS][31];
        p_d          = max32(par[PAR_P0], PW2);
        p0_d         = max32(par[PAR_P0], PW2);
        f_d          = max32(par[PAR_PMIN], PW2);
        d_d          = par[PAR_DELTA];
        na_d         = na_ld;
        cend_d       = s_abs - nd_ld;
        steps_done_d = '0;
        if (s_abs == '0)       state_d = ST_DONE;
        else if (na_ld != '0)  state_d = ST_ACCEL;
        else                   state_d = ST_CRUISE;
      end
      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        // decel steps rise with the lengthened period already applied
        if (state_q == ST_DECEL) fire_per = add_clamp(p_q, d_q, p0_q);
        if (abort) begin
          state_d = ST_DONE;
        end else if (due) begin
          if (steps_done_q == n_q) begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
          end else begin
            fire         = 1'b1;
            steps_done_d = steps_done_q + 32'd1;
            p_d          = fire_per;
            if (state_q == ST_ACCEL) begin
              p_d = sub_floor(p_q, d_q, f_q);
              if (steps_done_d == na_q) state_d = (cend_q > na_q) ? ST_CRUISE : ST_DECEL;
            end else if (state_q == ST_CRUISE) begin
              if (steps_done_d >= cend_q) state_d = ST_DECEL;
            end
          end
        end
      end
      ST_DONE: begin
        // finish stays up at least one cycle before start may release it
        if (finish_q && !start) begin
          state_d  = ST_IDLE;
          finish_d = 1'b0;
        end else begin
          finish_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      p_q          <= '0;
      p0_q         <= '0;
      f_q          <= '0;
      d_q          <= '0;
      na_q         <= '0;
      cend_q       <= '0;
      steps_done_q <= '0;
      dir_q        <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      p_q          <= p_d;
      p0_q         <= p0_d;
      f_q          <= f_d;
      d_q          <= d_d;
      na_q         <= na_d;
      cend_q       <= cend_d;
      steps_done_q <= steps_done_d;
      dir_q        <= dir_d;
      finish_q     <= finish_d;
    end
  end

  step_timer #(.PULSE_W(PULSE_W)) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .load   (tmr_load),
    .fire   (fire),
    .period (fire_per),
    .due    (due),
    .step   (step)
  );

  assign dir        = dir_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_ACCEL) ||
                      (state_q == ST_CRUISE) || (state_q == ST_DECEL);
  assign steps_done = steps_done_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_axis_step_generator.sv
// Directed bench for axis_step_generator: ramp spacing, short/zero/clamped moves, abort, reset.
module tb_axis_step_generator;
  import axis_step_generator_pkg::*;

  logic        clk, reset, start, abort;
  logic [31:0] par [0:4];
  logic        step, dir, busy, finish;
  logic [31:0] steps_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises[$];
  int widths[$];
  int fin_cyc = -1;
  int busy_cnt = 0;
  int cur_w = 0;
  bit saw_cruise = 0;
  logic step_prev = 0, fin_prev = 0;
  int t0;
  int tri_gap[9] = '{100, 80, 60, 40, 40, 40, 40, 60, 80};

  axis_step_generator #(.PULSE_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .par(par),
    .step(step), .dir(dir), .busy(busy), .steps_done(steps_done), .finish(finish)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step && !step_prev) rises.push_back(cyc);
    if (step) cur_w++;
    else if (step_prev) begin
      widths.push_back(cur_w);
      cur_w = 0;
    end
    if (finish && !fin_prev) fin_cyc = cyc;
    if (busy) busy_cnt++;
    if (dut.state_q == ST_CRUISE) saw_cruise = 1;
    step_prev = step;
    fin_prev  = finish;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rises.delete();
    widths.delete();
    fin_cyc = -1;
    busy_cnt = 0;
    cur_w = 0;
    saw_cruise = 0;
  endtask

  task automatic set_par(input int s, input int p0, input int pmin, input int d, input int a);
    par[0] = 32'(s); par[1] = 32'(p0); par[2] = 32'(pmin); par[3] = 32'(d); par[4] = 32'(a);
  endtask

  task automatic do_start(output int t);
    start = 1;
    t = cyc + 1;
  endtask

  task automatic wait_finish(input string tag, input int budget);
    int k;
    k = 0;
    while (!finish && k < budget) begin
      tick();
      k++;
    end
    check(tag, finish, 1);
  endtask

  task automatic release_start(input string tag);
    start = 0;
    tick();
    check({tag, "_fin_drop"}, finish, 0);
    check({tag, "_idle_busy"}, busy, 0);
    tick();
  endtask

  task automatic check_triangle(input string tag);
    check({tag, "_count"}, rises.size(), 10);
    if (rises.size() == 10) begin
      check({tag, "_first"}, rises[0], t0 + 2);
      for (int i = 0; i < 9; i++) check({tag, "_gap"}, rises[i+1] - rises[i], tri_gap[i]);
      check({tag, "_fin_gap"}, fin_cyc - rises[9], 100);
    end
    check({tag, "_steps_done"}, steps_done, 10);
    check({tag, "_busy_done"}, busy, 0);
    if (widths.size() > 0) check({tag, "_width"}, widths[0], 10);
  endtask

  initial begin
    reset = 0; start = 0; abort = 0;
    set_par(0, 0, 0, 0, 0);
    #1;
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_steps_done", steps_done, 0);
    tick(); tick();
    reset = 1;
    tick();

    // triangle profile; par scribbled mid-move must be ignored
    clear_mon();
    set_par(10, 100, 40, 20, 3);
    do_start(t0);
    repeat (5) tick();
    set_par(-7, 3, 1, 99, 0);
    wait_finish("tri_finish", 2000);
    check_triangle("tri");
    check("tri_dir", dir, 0);
    release_start("tri");

    // short reverse move: one accel, two decel, no cruise
    clear_mon();
    set_par(-3, 100, 40, 20, 5);
    do_start(t0);
    wait_finish("short_finish", 2000);
    check("short_dir", dir, 1);
    check("short_count", rises.size(), 3);
    check("short_no_cruise", saw_cruise, 0);
    if (rises.size() == 3) begin
      check("short_gap0", rises[1] - rises[0], 100);
      check("short_gap1", rises[2] - rises[1], 100);
      check("short_fin_gap", fin_cyc - rises[2], 100);
    end
    check("short_steps_done", steps_done, 3);
    release_start("short");

    // zero move
    clear_mon();
    set_par(0, 100, 40, 20, 3);
    do_start(t0);
    wait_finish("zero_finish", 20);
    check("zero_busy_cycles", busy_cnt, 1);
    check("zero_fin_time", fin_cyc, t0 + 2);
    check("zero_no_step", rises.size(), 0);
    check("zero_steps_done", steps_done, 0);
    release_start("zero");

    // clamped periods; start dropped mid-segment
    clear_mon();
    set_par(4, 5, 3, 1, 1);
    do_start(t0);
    repeat (30) tick();
    start = 0;
    wait_finish("clamp_finish", 500);
    check("clamp_count", rises.size(), 4);
    if (rises.size() == 4) begin
      for (int i = 0; i < 3; i++) check("clamp_gap", rises[i+1] - rises[i], 20);
      check("clamp_fin_gap", fin_cyc - rises[3], 20);
    end
    tick();
    check("clamp_fin_drop", finish, 0);
    check("clamp_busy", busy, 0);
    tick();

    // abort during the 4th pulse
    clear_mon();
    set_par(10, 100, 40, 20, 3);
    do_start(t0);
    for (int k = 0; k < 1000 && rises.size() < 4; k++) tick();
    check("abort_reach4", rises.size(), 4);
    tick(); tick();
    abort = 1;
    repeat (150) tick();
    check("abort_edges", rises.size(), 4);
    check("abort_widths", widths.size(), 4);
    if (widths.size() > 0) check("abort_last_width", widths[widths.size()-1], 10);
    check("abort_finish", finish, 1);
    check("abort_steps_done", steps_done, 4);
    check("abort_busy", busy, 0);
    abort = 0;
    release_start("abort");

    // reset 50 cycles into a triangle move, then rerun it
    clear_mon();
    do_start(t0);
    while (cyc < t0 + 50) tick();
    check("pre_rst_busy", busy, 1);
    #2 reset = 0;
    #1;
    check("mid_rst_step", step, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_steps_done", steps_done, 0);
    check("mid_rst_finish", finish, 0);
    check("mid_rst_dir", dir, 0);
    tick();
    clear_mon();
    reset = 1;
    t0 = cyc + 1;
    wait_finish("rerun_finish", 2000);
    check_triangle("rerun");
    release_start("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
